// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit per clock, then a single cycle to publish digits and the blanking mask.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]          state_reg;
    logic [WIDTH-1:0]    shreg_reg;
    logic [4*DIGITS-1:0] scratch_reg;
    logic [CW-1:0]       count_reg;
    logic                valid_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [DIGITS-1:0]   en_reg;

    logic [4*DIGITS-1:0] adjusted;
    logic [DIGITS-1:0]   nonzero;
    logic [DIGITS-1:0]   en_calc;

    // Digits are always <= 9 here, so the 4-bit +3 never wraps.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            assign d = scratch_reg[4*gi +: 4];
            assign adjusted[4*gi +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
            assign nonzero[gi] = |d;
            if (gi == 0) begin : g_lsd
                assign en_calc[gi] = 1'b1;
            end else begin : g_upper
                assign en_calc[gi] = |nonzero[DIGITS-1:gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
            bcd_reg     <= '0;
            en_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shreg_reg   <= bin_in;
                        scratch_reg <= '0;
                        count_reg   <= CW'(WIDTH);
                        valid_reg   <= 1'b0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_reg, shreg_reg} <= {adjusted, shreg_reg} << 1;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bcd_reg   <= scratch_reg;
                    en_reg    <= en_calc;
                    valid_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign valid    = valid_reg;
    assign bcd_out  = bcd_reg;
    assign digit_en = en_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed timing checks in the main
// process, result checks in a separate monitor against a decimal reference.
module tb_bin_to_bcd_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        valid;
    logic [39:0] bcd_out;
    logic [9:0]  digit_en;

    int checks = 0;
    int passes = 0;
    logic [49:0] exp_q[$];

    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .valid    (valid),
        .bcd_out  (bcd_out),
        .digit_en (digit_en)
    );

    always #5 clock = ~clock;

    // Reference: decimal digits by repeated division; enable by magnitude.
    function automatic logic [49:0] model(input logic [31:0] v);
        longint     x = longint'(v);
        longint     p = 1;
        logic [39:0] b = '0;
        logic [9:0]  e = '0;
        for (int i = 0; i < 10; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
            e[i] = (i == 0) || (longint'(v) >= p);
            p = p * 10;
        end
        return {e, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic start_conv(input logic [31:0] v, input bit push);
        bin_in = v;
        start  = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        bin_in = $urandom;
        if (push) exp_q.push_back(model(v));
    endtask

    task automatic wait_done(output int cycles, output int busy_hi);
        cycles  = 0;
        busy_hi = 0;
        while (!valid && cycles < 100) begin
            @(posedge clock); #1;
            cycles++;
            if (!valid && busy) busy_hi++;
        end
        if (!valid) check("done_timeout", 64'(valid), 64'd1);
    endtask

    // Monitor: each rising valid is one result to match against the queue.
    initial begin
        logic valid_prev = 1'b0;
        logic [49:0] e;
        logic ok;
        forever begin
            @(negedge clock);
            if (valid && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(bcd_out), 64'd0 - 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    ok = 1'b1;
                    for (int i = 0; i < 10; i++) if (bcd_out[4*i +: 4] > 4'd9) ok = 1'b0;
                    check("bcd_out", 64'(bcd_out), 64'(e[39:0]));
                    check("digit_en", 64'(digit_en), 64'(e[49:40]));
                    check("digits_le9", 64'(ok), 64'd1);
                    $display("result bcd=%010h en=%010b", bcd_out, digit_en);
                end
            end
            valid_prev = valid;
        end
    end

    initial begin
        int cyc, bh;
        logic [49:0] e100;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_en", 64'(digit_en), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Latency and busy window
        start_conv(32'd12345, 1'b1);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(cyc, bh);
        check("latency", 64'(cyc), 64'd33);
        check("busy_window", 64'(bh), 64'd32);
        check("busy_after_done", 64'(busy), 64'd0);
        check("direct_12345", 64'(bcd_out), 64'h12345);

        // Extremes
        start_conv(32'd0, 1'b1);
        wait_done(cyc, bh);
        check("zero_en", 64'(digit_en), 64'b1);
        start_conv(32'hFFFF_FFFF, 1'b1);
        wait_done(cyc, bh);
        check("max_bcd", 64'(bcd_out), 64'h42_9496_7295);

        // Starts while busy ignored; bin_in change after capture ignored
        bin_in = 32'd999;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        exp_q.push_back(model(32'd999));
        bh = 0;
        cyc = 0;
        for (int c = 1; c <= 40 && !valid; c++) begin
            start = (c == 5 || c == 20);
            if (c == 3) bin_in = 32'd7;
            @(posedge clock); #1;
            start = 1'b0;
            cyc = c;
            if (!valid && busy) bh++;
        end
        check("ignore_latency", 64'(cyc), 64'd33);
        check("ignore_busy", 64'(bh), 64'd32);
        bh = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (busy) bh++;
        end
        check("no_second_conv", 64'(bh), 64'd0);

        // Reset mid-conversion discards everything
        start_conv(32'd55, 1'b0);
        repeat (9) @(posedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_bcd", 64'(bcd_out), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        start_conv(32'd42, 1'b1);
        wait_done(cyc, bh);

        // Level-held start: back-to-back with one idle cycle
        e100   = model(32'd100);
        bin_in = 32'd100;
        start  = 1'b1;
        exp_q.push_back(e100);
        @(posedge clock); #1;
        wait_done(cyc, bh);
        check("held_busy_low", 64'(busy), 64'd0);
        bin_in = 32'd65536;
        exp_q.push_back(model(32'd65536));
        @(posedge clock); #1;
        check("held_reaccept", 64'(busy), 64'd1);
        check("held_valid_drop", 64'(valid), 64'd0);
        check("held_bcd_hold", 64'(bcd_out), 64'(e100[39:0]));
        wait_done(cyc, bh);
        start = 1'b0;
        check("held_latency", 64'(cyc), 64'd33);

        // Random sweep across magnitudes
        for (int n = 0; n < 1000; n++) begin
            start_conv($urandom >> $urandom_range(0, 31), 1'b1);
            wait_done(cyc, bh);
        end

        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
